dmux_4way: RTL and testbench

//   Registered 1-to-4 lane-select demultiplexer. Each cycle, bit entrada[sel]
//   is routed to output o<sel>; the three non-selected outputs are driven 0.

---
 rtl/dmux_4way.sv | 36 +++
 tb/tb_dmux_4way.sv | 119 +++++++++++
 2 files changed

// File: rtl/dmux_4way.sv
// Registered 1-to-4 lane demux: o<sel> <= entrada[sel], the other lanes <= 0.
// One-cycle latency and one new sample per cycle. There is no handshake, so it never backpressures.
module dmux_4way (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] entrada,
    input  logic [1:0] sel,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3
);

    logic [3:0] w_nxt;
    logic [3:0] r_o;

    // Default zero keeps the outputs one-hot-or-zero and prevents latch inference.
    always_comb begin
        w_nxt      = 4'b0000;
        w_nxt[sel] = entrada[sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o <= 4'b0000;
        end else begin
            r_o <= w_nxt;
        end
    end

    assign o0 = r_o[0];
    assign o1 = r_o[1];
    assign o2 = r_o[2];
    assign o3 = r_o[3];

endmodule

// File: tb/tb_dmux_4way.sv
// Directed and random checks of dmux_4way against a lane-select reference model.
module tb_dmux_4way;

    logic       clk;
    logic       rst;
    logic [3:0] entrada;
    logic [1:0] sel;
    logic       o0, o1, o2, o3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] prev_exp;
    logic       prev_vld = 1'b0;

    dmux_4way dut (
        .clk     (clk),
        .rst     (rst),
        .entrada (entrada),
        .sel     (sel),
        .o0      (o0),
        .o1      (o1),
        .o2      (o2),
        .o3      (o3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the selected lane carries its own data bit, and every other lane reads 0.
    function automatic logic [3:0] ref_out(input logic [3:0] e, input logic [1:0] s);
        logic [3:0] r;
        r = 4'b0000;
        if (((e >> s) & 4'd1) == 4'd1)
            r = 4'd1 << s;
        return r;
    endfunction

    function automatic logic [3:0] obs();
        return {o3, o2, o1, o0};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed o3..o0=%b expected %b", tag, got, exp);
        end
    endtask

    // The task applies inputs just after a rising edge. It first confirms that the outputs
    // still hold the previous value, which shows no combinational path.
    // It then checks the outputs one edge later.
    task automatic cycle(input logic r, input logic [3:0] e, input logic [1:0] s,
                         input logic [3:0] exp, input string tag);
        logic [3:0] got;
        rst = r; entrada = e; sel = s;
        #2;
        if (prev_vld)
            check({tag, "_hold"}, obs(), prev_exp);
        @(posedge clk);
        #1;
        got = obs();
        check(tag, got, exp);
        n_assert++;
        assert (($countones(got) <= 1) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s_onehot: observed o3..o0=%b expected popcount<=1", tag, got);
        end
        prev_exp = exp;
        prev_vld = 1'b1;
    endtask

    initial begin
        logic [3:0] e;
        logic [1:0] s;
        logic       r;
        rst = 1'b1; entrada = 4'b1111; sel = 2'b00;
        @(posedge clk);
        #1;

        // Reset with all lanes high
        cycle(1'b1, 4'b1111, 2'b00, 4'b0000, "reset0");
        cycle(1'b1, 4'b1111, 2'b00, 4'b0000, "reset1");

        // Only lane 0 high
        cycle(1'b0, 4'b0001, 2'b00, 4'b0001, "lane0_s0");
        cycle(1'b0, 4'b0001, 2'b01, 4'b0000, "lane0_s1");
        cycle(1'b0, 4'b0001, 2'b10, 4'b0000, "lane0_s2");
        cycle(1'b0, 4'b0001, 2'b11, 4'b0000, "lane0_s3");

        // All lanes high, sweep the select
        cycle(1'b0, 4'b1111, 2'b00, 4'b0001, "all_s0");
        cycle(1'b0, 4'b1111, 2'b01, 4'b0010, "all_s1");
        cycle(1'b0, 4'b1111, 2'b10, 4'b0100, "all_s2");
        cycle(1'b0, 4'b1111, 2'b11, 4'b1000, "all_s3");

        // Alternating lanes
        cycle(1'b0, 4'b1010, 2'b01, 4'b0010, "alt_s1");
        cycle(1'b0, 4'b1010, 2'b11, 4'b1000, "alt_s3");
        cycle(1'b0, 4'b1010, 2'b00, 4'b0000, "alt_s0");

        // Reset asserted mid-stream while inputs stay held
        cycle(1'b0, 4'b1000, 2'b11, 4'b1000, "stream_s3");
        cycle(1'b1, 4'b1000, 2'b11, 4'b0000, "stream_rst");

        // Random traffic with occasional resets
        for (int i = 0; i < 1000; i++) begin
            e = 4'($urandom);
            s = 2'($urandom);
            r = ($urandom_range(0, 49) == 0);
            cycle(r, e, s, r ? 4'b0000 : ref_out(e, s), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
